mic_clkgen: RTL and testbench

MIC_CLKGEN -- requirements
Module: mic_clkgen

---
 rtl/mic_clkgen_pkg.sv | 17 +
 rtl/mic_clkgen_ch.sv | 97 +++++++++
 rtl/mic_clkgen.sv | 61 ++++++
 tb/tb_mic_clkgen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mic_clkgen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mic_clkgen_pkg
//  Description : Shared defaults and types for the microphone clock generator.
//  Revision    : 1.0  initial release
// ============================================================================
package mic_clkgen_pkg;

    // Default width of the ratio and counter of one channel
    localparam int unsigned C_CNT_W   = 11;
    // Ratio every channel runs with after reset
    localparam int unsigned C_DEF_DIV = 6;

    typedef logic [C_CNT_W-1:0] div_t;

endpackage : mic_clkgen_pkg
`default_nettype wire

// File: rtl/mic_clkgen_ch.sv
`default_nettype none
// ============================================================================
//  Module      : mic_clkgen_ch
//  Description : One divider channel: tick counter, active/pending ratio,
//                one-cycle enable strobe and registered divided square wave.
//  Revision    : 1.0  initial release
// ============================================================================
module mic_clkgen_ch
    import mic_clkgen_pkg::*;
#(
    parameter int unsigned CNT_W   = C_CNT_W,
    parameter int unsigned DEF_DIV = C_DEF_DIV
) (
    input  logic             s_clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             sync_i,
    input  logic             we_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             pend_o,
    output logic             ce_o,
    output logic             clk_o
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_pend;
    logic             r_pend;
    logic             r_ce;
    logic             r_clk;

    logic             w_active;
    logic [CNT_W-1:0] w_last;
    logic             w_terminal;

    // A zero ratio parks the channel; its ratio is never decremented
    assign w_active   = (r_div_act != '0);
    assign w_last     = w_active ? (r_div_act - C_ONE) : '0;
    assign w_terminal = w_active && tick_i && (r_cnt == w_last);

    // Counter, ratio hand-over and output strobes; a write in the same cycle
    // as a hand-over always lands in the pending slot for the next one
    always_ff @(posedge s_clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_div_act  <= CNT_W'(DEF_DIV);
            r_div_pend <= '0;
            r_pend     <= 1'b0;
            r_ce       <= 1'b0;
            r_clk      <= 1'b0;
        end else if (sync_i) begin
            r_cnt <= '0;
            r_ce  <= 1'b0;
            r_clk <= 1'b0;
            if (r_pend) begin
                r_div_act <= r_div_pend;
            end
            r_pend <= 1'b0;
            if (we_i) begin
                r_div_pend <= div_i;
                r_pend     <= 1'b1;
            end
        end else begin
            r_ce <= 1'b0;
            if (!w_active) begin
                // Parked: pick up a new ratio on the first edge it is seen
                r_cnt <= '0;
                if (r_pend) begin
                    r_div_act <= r_div_pend;
                    r_pend    <= 1'b0;
                end
            end else if (w_terminal) begin
                r_cnt <= '0;
                r_ce  <= 1'b1;
                r_clk <= ~r_clk;
                if (r_pend) begin
                    r_div_act <= r_div_pend;
                    r_pend    <= 1'b0;
                end
            end else if (tick_i) begin
                r_cnt <= r_cnt + C_ONE;
            end
            if (we_i) begin
                r_div_pend <= div_i;
                r_pend     <= 1'b1;
            end
        end
    end

    assign pend_o = r_pend;
    assign ce_o   = r_ce;
    assign clk_o  = r_clk;

endmodule : mic_clkgen_ch
`default_nettype wire

// File: rtl/mic_clkgen.sv
`default_nettype none
// ============================================================================
//  Module      : mic_clkgen
//  Description : Multi-channel clock-enable generator. Each channel divides
//                either s_clk or the previous channel's enable strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module mic_clkgen
    import mic_clkgen_pkg::*;
#(
    parameter  int unsigned NUM_CH  = 2,
    parameter  int unsigned CNT_W   = C_CNT_W,
    parameter  int unsigned DEF_DIV = C_DEF_DIV,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              s_clk,
    input  logic              rst,
    input  logic              sync_i,
    input  logic [NUM_CH-1:0] casc_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [CNT_W-1:0]  cfg_div_i,
    output logic [NUM_CH-1:0] cfg_pend_o,
    output logic [NUM_CH-1:0] ce_o,
    output logic [NUM_CH-1:0] clk_o
);

    logic [NUM_CH-1:0] w_casc;
    logic [NUM_CH-1:0] w_prev_ce;
    logic [NUM_CH-1:0] w_tick;

    // Channel 0 has no upstream stage, so its cascade select is forced off.
    // A cascaded channel ticks on the registered strobe of its neighbour,
    // which gives it one cycle of latency relative to that strobe.
    assign w_casc    = casc_i & ~NUM_CH'(1);
    assign w_prev_ce = ce_o << 1;
    assign w_tick    = ~w_casc | w_prev_ce;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic w_we;

        assign w_we = cfg_we_i && (cfg_ch_i == CH_W'(k));

        mic_clkgen_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .s_clk  (s_clk),
            .rst    (rst),
            .tick_i (w_tick[k]),
            .sync_i (sync_i),
            .we_i   (w_we),
            .div_i  (cfg_div_i),
            .pend_o (cfg_pend_o[k]),
            .ce_o   (ce_o[k]),
            .clk_o  (clk_o[k])
        );
    end

endmodule : mic_clkgen
`default_nettype wire

// File: tb/tb_mic_clkgen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mic_clkgen
//  Description : Self-checking bench for mic_clkgen: directed scenarios plus
//                randomized traffic against a behavioural channel model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mic_clkgen;

    localparam int unsigned NUM_CH  = 3;
    localparam int unsigned CNT_W   = 11;
    localparam int unsigned DEF_DIV = 6;
    localparam int unsigned CH_W    = 2;

    logic              s_clk;
    logic              rst;
    logic              sync_i;
    logic [NUM_CH-1:0] casc_i;
    logic              cfg_we_i;
    logic [CH_W-1:0]   cfg_ch_i;
    logic [CNT_W-1:0]  cfg_div_i;
    logic [NUM_CH-1:0] cfg_pend_o;
    logic [NUM_CH-1:0] ce_o;
    logic [NUM_CH-1:0] clk_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: ticks seen in the current period, ratios
    int unsigned       m_cnt  [NUM_CH];
    int unsigned       m_act  [NUM_CH];
    int unsigned       m_pval [NUM_CH];
    logic [NUM_CH-1:0] m_pend = '0;
    logic [NUM_CH-1:0] m_ce   = '0;
    logic [NUM_CH-1:0] m_clk  = '0;

    mic_clkgen #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .s_clk      (s_clk),
        .rst        (rst),
        .sync_i     (sync_i),
        .casc_i     (casc_i),
        .cfg_we_i   (cfg_we_i),
        .cfg_ch_i   (cfg_ch_i),
        .cfg_div_i  (cfg_div_i),
        .cfg_pend_o (cfg_pend_o),
        .ce_o       (ce_o),
        .clk_o      (clk_o)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One rising edge of the reference: a channel period is "D ticks", the
    // strobe marks the end of a period, and the square wave flips there.
    task automatic model_step();
        logic [NUM_CH-1:0] prev_ce;
        logic              tick;
        prev_ce = m_ce;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rst) begin
                m_cnt[k]  = 0;
                m_act[k]  = DEF_DIV;
                m_pval[k] = 0;
                m_pend[k] = 1'b0;
                m_ce[k]   = 1'b0;
                m_clk[k]  = 1'b0;
            end else if (sync_i) begin
                m_cnt[k] = 0;
                m_ce[k]  = 1'b0;
                m_clk[k] = 1'b0;
                if (m_pend[k]) m_act[k] = m_pval[k];
                m_pend[k] = 1'b0;
                if (cfg_we_i && cfg_ch_i == k) begin
                    m_pval[k] = cfg_div_i;
                    m_pend[k] = 1'b1;
                end
            end else begin
                tick    = (k == 0) ? 1'b1 : (!casc_i[k] || prev_ce[k-1]);
                m_ce[k] = 1'b0;
                if (m_act[k] == 0) begin
                    m_cnt[k] = 0;
                    if (m_pend[k]) begin
                        m_act[k]  = m_pval[k];
                        m_pend[k] = 1'b0;
                    end
                end else if (tick) begin
                    m_cnt[k] = m_cnt[k] + 1;
                    if (m_cnt[k] == m_act[k]) begin
                        m_cnt[k] = 0;
                        m_ce[k]  = 1'b1;
                        m_clk[k] = ~m_clk[k];
                        if (m_pend[k]) begin
                            m_act[k]  = m_pval[k];
                            m_pend[k] = 1'b0;
                        end
                    end
                end
                if (cfg_we_i && cfg_ch_i == k) begin
                    m_pval[k] = cfg_div_i;
                    m_pend[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge s_clk);
        model_step();
        #1;
        check("ce_o", ce_o, m_ce);
        check("clk_o", clk_o, m_clk);
        check("cfg_pend_o", cfg_pend_o, m_pend);
    endtask

    task automatic write_cfg(input logic en, input int ch, input int div);
        cfg_we_i  = en;
        cfg_ch_i  = CH_W'(ch);
        cfg_div_i = CNT_W'(div);
    endtask

    initial begin
        rst = 1'b1; sync_i = 1'b0; casc_i = '0;
        write_cfg(1'b0, 0, 0);
        cycle();
        cycle();
        check("rst_ce", ce_o, 0);
        check("rst_clk", clk_o, 0);
        check("rst_pend", cfg_pend_o, 0);

        // Default ratio 6 straight out of reset
        rst = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            cycle();
            check("def_ce0", ce_o[0], (e % 6 == 0));
            check("def_clk0", clk_o[0], (e / 6) % 2);
        end

        // Cascade: ch1 divides ch0's strobe by 2
        write_cfg(1'b1, 1, 2);
        casc_i = 3'b010;
        cycle();
        write_cfg(1'b0, 0, 0);
        sync_i = 1'b1;
        cycle();
        sync_i = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            cycle();
            check("casc_ce0", ce_o[0], (e % 6 == 0));
            check("casc_ce1", ce_o[1], (e >= 13) && ((e - 13) % 12 == 0));
            check("casc_clk1", clk_o[1], (e >= 13) && (e < 25));
        end

        // Ratio 3 written mid-period: periods of 6 then 3
        casc_i = '0;
        sync_i = 1'b1;
        cycle();
        sync_i = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            write_cfg(e == 2, 0, 3);
            cycle();
            check("upd_pend0", cfg_pend_o[0], (e >= 2) && (e < 6));
            check("upd_ce0", ce_o[0], (e == 6) || (e == 9) || (e == 12));
        end
        write_cfg(1'b0, 0, 0);

        // Overwritten pending value, disable with 0, re-enable with 2
        sync_i = 1'b1;
        cycle();
        sync_i = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            case (e)
                1:       write_cfg(1'b1, 0, 4);
                2:       write_cfg(1'b1, 0, 5);
                14:      write_cfg(1'b1, 0, 0);
                30:      write_cfg(1'b1, 0, 2);
                default: write_cfg(1'b0, 0, 0);
            endcase
            cycle();
            check("ovr_ce0", ce_o[0],
                  (e == 3) || (e == 8) || (e == 13) || (e == 18) ||
                  (e == 33) || (e == 35) || (e == 37) || (e == 39));
        end
        write_cfg(1'b0, 0, 0);

        // Sync mid-period with ch2 update pending
        sync_i = 1'b1;
        cycle();
        sync_i = 1'b0;
        write_cfg(1'b1, 2, 4);
        cycle();
        write_cfg(1'b0, 0, 0);
        sync_i = 1'b1;
        cycle();
        sync_i = 1'b0;
        check("sync_ce", ce_o, 0);
        check("sync_clk", clk_o, 0);
        check("sync_pend", cfg_pend_o, 0);
        for (int e = 3; e <= 12; e++) begin
            cycle();
            check("sync_ce2", ce_o[2], (e == 6) || (e == 10));
        end

        // Reset dominates a simultaneous sync and write
        rst = 1'b1; sync_i = 1'b1;
        write_cfg(1'b1, 0, 7);
        cycle();
        check("rdom_ce", ce_o, 0);
        check("rdom_clk", clk_o, 0);
        check("rdom_pend", cfg_pend_o, 0);
        rst = 1'b0; sync_i = 1'b0;
        write_cfg(1'b0, 0, 0);
        for (int e = 1; e <= 12; e++) begin
            cycle();
            check("rdom_ce_all", ce_o, (e % 6 == 0) ? 7 : 0);
            check("rdom_clk_all", clk_o, ((e / 6) % 2 == 1) ? 7 : 0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst    = ($urandom_range(0, 299) == 0);
            sync_i = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 199) == 0) casc_i = NUM_CH'($urandom_range(0, 7));
            write_cfg($urandom_range(0, 5) == 0, $urandom_range(0, NUM_CH - 1),
                      $urandom_range(0, 7));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mic_clkgen
`default_nettype wire
